// File: rtl/vmem_pkg.sv
// Shared types and constants for the vector memory responder.
package vmem_pkg;

   localparam int VMEM_WORD_BYTES  = 4;
   localparam int VMEM_DATA_WIDTH  = 32;
   localparam int VMEM_LANES       = 4;
   localparam int VMEM_ADDR_BITS   = 32;
   localparam int VMEM_TICKET_BITS = 5;
   localparam int VMEM_VL_BITS     = $clog2(VMEM_LANES + 1);

   typedef enum logic [1:0] {
      IDLE,
      ELEM,
      RESP
   } vmem_state_e;

   typedef struct packed {
      logic                                  store;
      logic [VMEM_ADDR_BITS-1:0]             addr;
      logic [31:0]                           stride;
      logic [VMEM_VL_BITS-1:0]               vl;
      logic [VMEM_LANES-1:0]                 mask;
      logic [VMEM_LANES*VMEM_DATA_WIDTH-1:0] data;
      logic [VMEM_TICKET_BITS-1:0]           ticket;
   } vmem_req_t;

endpackage

// File: rtl/vmem_req_fifo.sv
// Synchronous request FIFO; head entry is visible combinationally on rdata.
module vmem_req_fifo
   import vmem_pkg::*;
#(
   parameter int  DEPTH    = 2,
   parameter type T        = vmem_req_t,
   parameter int  CNT_BITS = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                push,
   input  logic                pop,
   input  T                    wdata,
   output T                    rdata,
   output logic                full,
   output logic                empty,
   output logic [CNT_BITS-1:0] count
);

   localparam int PTR_BITS = $clog2(DEPTH);

   T                    store_q [DEPTH];
   logic [PTR_BITS-1:0] wr_ptr_q;
   logic [PTR_BITS-1:0] rd_ptr_q;
   logic [CNT_BITS-1:0] count_q;

   // NOTE: storage arrays are left unreset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) store_q[wr_ptr_q] <= wdata;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_BITS'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_BITS'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_BITS'(1);
            2'b01:   count_q <= count_q - CNT_BITS'(1);
            default: ;
         endcase
      end
   end

   assign rdata = store_q[rd_ptr_q];
   assign full  = (count_q == CNT_BITS'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/vmem_responder.sv
// Vector memory responder: serializes queued vector requests against a local word memory.
// Optional strided addressing is enabled by defining VMEM_STRIDE_EN; otherwise unit stride.
module vmem_responder
   import vmem_pkg::*;
#(
   parameter int DATA_WIDTH   = VMEM_DATA_WIDTH,
   parameter int VECTOR_LANES = VMEM_LANES,
   parameter int ADDR_BITS    = VMEM_ADDR_BITS,
   parameter int TICKET_BITS  = VMEM_TICKET_BITS,
   parameter int DEPTH_WORDS  = 1024,
   parameter int QUEUE_DEPTH  = 2
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 req_valid_i,
   output logic                                 req_ready_o,
   input  logic                                 req_store_i,
   input  logic [ADDR_BITS-1:0]                 req_addr_i,
   input  logic [31:0]                          req_stride_i,
   input  logic [$clog2(VECTOR_LANES+1)-1:0]    req_vl_i,
   input  logic [VECTOR_LANES-1:0]              req_mask_i,
   input  logic [VECTOR_LANES*DATA_WIDTH-1:0]   req_data_i,
   input  logic [TICKET_BITS-1:0]               req_ticket_i,
   output logic                                 resp_valid_o,
   input  logic                                 resp_ready_i,
   output logic                                 resp_store_o,
   output logic [TICKET_BITS-1:0]               resp_ticket_o,
   output logic [VECTOR_LANES*DATA_WIDTH-1:0]   resp_data_o,
   output logic                                 resp_err_o
);

   localparam int VL_BITS   = $clog2(VECTOR_LANES + 1);
   localparam int LANE_BITS = (VECTOR_LANES > 1) ? $clog2(VECTOR_LANES) : 1;
   localparam int IDX_BITS  = $clog2(DEPTH_WORDS);
   localparam int CNT_BITS  = $clog2(QUEUE_DEPTH + 1);

   vmem_req_t           push_req;
   vmem_req_t           head;
   logic                fifo_full;
   logic                fifo_empty;
   logic [CNT_BITS-1:0] fifo_count;
   logic                push;
   logic                pop;
   logic                unused_bits;

   vmem_state_e                      state_q;
   logic                             store_q;
   logic [ADDR_BITS-1:0]             addr_q;
   logic [VL_BITS-1:0]               vl_q;
   logic [VECTOR_LANES-1:0]          mask_q;
   logic [VECTOR_LANES*DATA_WIDTH-1:0] data_q;
   logic [LANE_BITS-1:0]             e_q;
   logic                             drain_q;
   logic                             pend_valid_q;
   logic [LANE_BITS-1:0]             pend_lane_q;
   logic                             resp_valid_q;
   logic                             resp_store_q;
   logic [TICKET_BITS-1:0]           resp_ticket_q;
   logic [VECTOR_LANES*DATA_WIDTH-1:0] resp_data_q;
   logic                             resp_err_q;

   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
   logic [DATA_WIDTH-1:0] rd_word_q;

   logic                  elem_go;
   logic                  lane_active;
   logic                  aligned;
   logic                  mem_we;
   logic                  mem_re;
   logic                  last_elem;
   logic [IDX_BITS-1:0]   word_idx;
   logic [DATA_WIDTH-1:0] wr_word;
   logic [31:0]           stride_step;
   logic [ADDR_BITS-1:0]  addr_step;

   always_comb begin
      push_req        = '0;
      push_req.store  = req_store_i;
      push_req.addr   = req_addr_i;
      push_req.stride = req_stride_i;
      push_req.vl     = req_vl_i;
      push_req.mask   = req_mask_i;
      push_req.data   = req_data_i;
      push_req.ticket = req_ticket_i;
   end

   // No pass-through when full: readiness depends only on the registered count.
   assign req_ready_o = (fifo_count < CNT_BITS'(QUEUE_DEPTH));
   assign push        = req_valid_i && req_ready_o;
   assign pop         = (state_q == IDLE) && !fifo_empty;

   vmem_req_fifo #(
      .DEPTH (QUEUE_DEPTH),
      .T     (vmem_req_t)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata (push_req),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

`ifdef VMEM_STRIDE_EN
   logic [31:0] stride_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   stride_q <= '0;
      else if (pop) stride_q <= head.stride;
   end

   assign stride_step = stride_q;
   assign unused_bits = fifo_full;
`else
   assign stride_step = 32'(VMEM_WORD_BYTES);
   assign unused_bits = ^{fifo_full, head.stride};
`endif

   // NOTE: every combinational output gets a default first so no latch can be inferred.
   always_comb begin
      elem_go     = (state_q == ELEM) && !drain_q;
      lane_active = mask_q[e_q];
      aligned     = (addr_q[1:0] == 2'b00);
      mem_we      = elem_go && lane_active && aligned && store_q;
      mem_re      = elem_go && lane_active && aligned && !store_q;
      last_elem   = ((VL_BITS'(e_q) + VL_BITS'(1)) == vl_q);
      word_idx    = addr_q[IDX_BITS+1:2];
      wr_word     = data_q[e_q*DATA_WIDTH +: DATA_WIDTH];
      addr_step   = ADDR_BITS'($signed(stride_step));
   end

   // Single-port word memory with a registered read port.
   always_ff @(posedge clk) begin
      if (mem_we)      mem[word_idx] <= wr_word;
      else if (mem_re) rd_word_q     <= mem[word_idx];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         store_q       <= 1'b0;
         addr_q        <= '0;
         vl_q          <= '0;
         mask_q        <= '0;
         data_q        <= '0;
         e_q           <= '0;
         drain_q       <= 1'b0;
         pend_valid_q  <= 1'b0;
         pend_lane_q   <= '0;
         resp_valid_q  <= 1'b0;
         resp_store_q  <= 1'b0;
         resp_ticket_q <= '0;
         resp_data_q   <= '0;
         resp_err_q    <= 1'b0;
      end else begin
         // Read data lands one cycle after the access; drain_q covers the last element.
         pend_valid_q <= 1'b0;
         for (int l = 0; l < VECTOR_LANES; l++) begin
            if (pend_valid_q && (pend_lane_q == LANE_BITS'(l)))
               resp_data_q[l*DATA_WIDTH +: DATA_WIDTH] <= rd_word_q;
         end

         case (state_q)
            IDLE: begin
               if (pop) begin
                  store_q       <= head.store;
                  addr_q        <= head.addr;
                  vl_q          <= head.vl;
                  mask_q        <= head.mask;
                  data_q        <= head.data;
                  e_q           <= '0;
                  drain_q       <= 1'b0;
                  resp_store_q  <= head.store;
                  resp_ticket_q <= head.ticket;
                  resp_data_q   <= '0;
                  resp_err_q    <= 1'b0;
                  if (head.vl == '0) begin
                     state_q      <= RESP;
                     resp_valid_q <= 1'b1;
                  end else begin
                     state_q <= ELEM;
                  end
               end
            end
            ELEM: begin
               if (drain_q) begin
                  drain_q      <= 1'b0;
                  state_q      <= RESP;
                  resp_valid_q <= 1'b1;
               end else begin
                  if (lane_active && !aligned) resp_err_q <= 1'b1;
                  pend_valid_q <= mem_re;
                  pend_lane_q  <= e_q;
                  addr_q       <= addr_q + addr_step;
                  if (last_elem) drain_q <= 1'b1;
                  else           e_q     <= e_q + LANE_BITS'(1);
               end
            end
            RESP: begin
               if (resp_ready_i) begin
                  resp_valid_q <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign resp_valid_o  = resp_valid_q;
   assign resp_store_o  = resp_store_q;
   assign resp_ticket_o = resp_ticket_q;
   assign resp_data_o   = resp_data_q;
   assign resp_err_o    = resp_err_q;

endmodule

// File: tb/tb_vmem_responder.sv
// Directed bench for vmem_responder: latency, data, masking, backpressure, errors, wrap, reset.
module tb_vmem_responder;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req_valid;
   logic         req_ready;
   logic         req_store;
   logic [31:0]  req_addr;
   logic [31:0]  req_stride;
   logic [2:0]   req_vl;
   logic [3:0]   req_mask;
   logic [127:0] req_data;
   logic [4:0]   req_ticket;
   logic         resp_valid;
   logic         resp_ready;
   logic         resp_store;
   logic [4:0]   resp_ticket;
   logic [127:0] resp_data;
   logic         resp_err;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   vmem_responder dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready),
      .req_store_i   (req_store),
      .req_addr_i    (req_addr),
      .req_stride_i  (req_stride),
      .req_vl_i      (req_vl),
      .req_mask_i    (req_mask),
      .req_data_i    (req_data),
      .req_ticket_i  (req_ticket),
      .resp_valid_o  (resp_valid),
      .resp_ready_i  (resp_ready),
      .resp_store_o  (resp_store),
      .resp_ticket_o (resp_ticket),
      .resp_data_o   (resp_data),
      .resp_err_o    (resp_err)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_req(input logic st, input logic [31:0] addr, input logic [31:0] stride,
                           input logic [2:0] vl, input logic [3:0] mask, input logic [127:0] data,
                           input logic [4:0] tkt);
      int guard;
      @(negedge clk);
      req_valid  = 1'b1;
      req_store  = st;
      req_addr   = addr;
      req_stride = stride;
      req_vl     = vl;
      req_mask   = mask;
      req_data   = data;
      req_ticket = tkt;
      guard = 0;
      while (!req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("push_ready", req_ready, 1'b1);
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   // k = number of clock edges after the accepting edge until resp_valid is seen.
   task automatic wait_resp(output int k);
      k = 0;
      @(negedge clk);
      while (!resp_valid && k < 60) begin
         @(negedge clk);
         k++;
      end
      check("resp_valid_seen", resp_valid, 1'b1);
   endtask

   task automatic take_resp();
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
   endtask

   initial begin
      int k;
      int seen;
      logic [127:0] exp_masked;

      rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_addr = '0; req_stride = 32'd4;
      req_vl = '0; req_mask = '0; req_data = '0; req_ticket = '0; resp_ready = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_valid", resp_valid, 1'b0);
      check("rst_store", resp_store, 1'b0);
      check("rst_ticket", resp_ticket, 5'd0);
      check("rst_data", resp_data, 128'd0);
      check("rst_err", resp_err, 1'b0);
      check("rst_ready", req_ready, 1'b1);
      rst_n = 1'b1;

      // Unit-stride store then load of the same words
      push_req(1'b1, 32'h100, 32'd4, 3'd4, 4'hF, {32'd4, 32'd3, 32'd2, 32'd1}, 5'd1);
      wait_resp(k);
      check("st_latency", k, 6);
      check("st_store", resp_store, 1'b1);
      check("st_ticket", resp_ticket, 5'd1);
      check("st_err", resp_err, 1'b0);
      take_resp();

      push_req(1'b0, 32'h100, 32'd4, 3'd4, 4'hF, 128'd0, 5'd2);
      wait_resp(k);
      check("ld_latency", k, 6);
      check("ld_data", resp_data, {32'd4, 32'd3, 32'd2, 32'd1});
      check("ld_store", resp_store, 1'b0);
      check("ld_ticket", resp_ticket, 5'd2);
      take_resp();

      // Fill 0x110..0x12C, then masked load with stride -8
      push_req(1'b1, 32'h110, 32'd4, 3'd4, 4'hF, {32'h44, 32'h33, 32'h22, 32'h11}, 5'd3);
      wait_resp(k);
      take_resp();
      push_req(1'b1, 32'h120, 32'd4, 3'd4, 4'hF, {32'hD, 32'hC, 32'hB, 32'hA}, 5'd4);
      wait_resp(k);
      take_resp();
      push_req(1'b0, 32'h120, 32'hFFFF_FFF8, 3'd4, 4'b0101, 128'd0, 5'd8);
      wait_resp(k);
`ifdef VMEM_STRIDE_EN
      exp_masked = {32'd0, 32'h11, 32'd0, 32'hA};
`else
      exp_masked = {32'd0, 32'hC, 32'd0, 32'hA};
`endif
      check("masked_data", resp_data, exp_masked);
      check("masked_ticket", resp_ticket, 5'd8);
      take_resp();

      // Backpressure: three requests queue up behind a stalled response
      push_req(1'b0, 32'h100, 32'd4, 3'd4, 4'hF, 128'd0, 5'd5);
      push_req(1'b0, 32'h120, 32'd4, 3'd2, 4'h3, 128'd0, 5'd6);
      push_req(1'b0, 32'h104, 32'd4, 3'd1, 4'h1, 128'd0, 5'd7);
      @(negedge clk);
      req_valid = 1'b1; req_store = 1'b0; req_addr = 32'h100; req_vl = 3'd1;
      req_mask = 4'h1; req_ticket = 5'd9;
      repeat (4) begin
         @(negedge clk);
         check("bp_refused", req_ready, 1'b0);
      end
      req_valid = 1'b0;
      wait_resp(k);
      repeat (5) @(negedge clk);
      check("bp_a_valid", resp_valid, 1'b1);
      check("bp_a_ticket", resp_ticket, 5'd5);
      check("bp_a_data", resp_data, {32'd4, 32'd3, 32'd2, 32'd1});
      take_resp();
      wait_resp(k);
      check("bp_b_ticket", resp_ticket, 5'd6);
      check("bp_b_data", resp_data, {32'd0, 32'd0, 32'hB, 32'hA});
      take_resp();
      wait_resp(k);
      check("bp_c_ticket", resp_ticket, 5'd7);
      check("bp_c_data", resp_data, 128'h2);
      take_resp();
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (resp_valid) seen++;
      end
      check("bp_no_extra", seen, 0);

      // vl = 0 gives an empty response one edge after acceptance
      push_req(1'b0, 32'h100, 32'd4, 3'd0, 4'hF, 128'd0, 5'd11);
      wait_resp(k);
      check("vl0_latency", k, 1);
      check("vl0_data", resp_data, 128'd0);
      check("vl0_ticket", resp_ticket, 5'd11);
      check("vl0_err", resp_err, 1'b0);
      take_resp();

      // Misaligned store is flagged and not written
      push_req(1'b1, 32'h102, 32'd4, 3'd1, 4'h1, 128'hDEAD, 5'd10);
      wait_resp(k);
      check("mis_st_latency", k, 3);
      check("mis_st_err", resp_err, 1'b1);
      take_resp();
      push_req(1'b0, 32'h100, 32'd4, 3'd1, 4'h1, 128'd0, 5'd12);
      wait_resp(k);
      check("mis_nowrite_data", resp_data, 128'h1);
      check("mis_err_cleared", resp_err, 1'b0);
      take_resp();
      push_req(1'b0, 32'h102, 32'd4, 3'd1, 4'h1, 128'd0, 5'd13);
      wait_resp(k);
      check("mis_ld_err", resp_err, 1'b1);
      check("mis_ld_data", resp_data, 128'd0);
      take_resp();

      // Address wrap: element 1 of a store at 0xFFFF_FFFC lands at 0x0
      push_req(1'b1, 32'hFFFF_FFFC, 32'd4, 3'd2, 4'h3, {32'd0, 32'd0, 32'h77, 32'h66}, 5'd14);
      wait_resp(k);
      take_resp();
      push_req(1'b0, 32'h0, 32'd4, 3'd1, 4'h1, 128'd0, 5'd15);
      wait_resp(k);
      check("wrap_lane1", resp_data, 128'h77);
      take_resp();
      push_req(1'b0, 32'hFFC, 32'd4, 3'd1, 4'h1, 128'd0, 5'd16);
      wait_resp(k);
      check("wrap_alias", resp_data, 128'h66);
      take_resp();

      // Reset mid-ELEM discards the request without a response
      push_req(1'b0, 32'h100, 32'd4, 3'd4, 4'hF, 128'd0, 5'd17);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", resp_valid, 1'b0);
      check("mid_rst_ticket", resp_ticket, 5'd0);
      check("mid_rst_store", resp_store, 1'b0);
      check("mid_rst_data", resp_data, 128'd0);
      check("mid_rst_err", resp_err, 1'b0);
      check("mid_rst_ready", req_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (resp_valid) seen++;
      end
      check("mid_rst_no_resp", seen, 0);
      check("post_rst_ready", req_ready, 1'b1);

      // Memory contents survive reset
      push_req(1'b0, 32'h100, 32'd4, 3'd4, 4'hF, 128'd0, 5'd18);
      wait_resp(k);
      check("post_rst_latency", k, 6);
      check("post_rst_data", resp_data, {32'd4, 32'd3, 32'd2, 32'd1});
      check("post_rst_ticket", resp_ticket, 5'd18);
      take_resp();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
